// File: rtl/vc_insert_ctrl.sv
// Victim-cache insert controller.
// Accepts L1 evictions and installs them into a NUM_WAYS victim tag store.
// It merges a duplicate tag into the existing way, otherwise uses the lowest
// invalid way, otherwise replaces the round-robin victim. A dirty victim is
// written back to memory before it is overwritten.
// Ports:
//   clk, rst                                  clock, async active-high reset
//   evict_valid/ready/tag/dirty               eviction offer from L1
//   inval_req/inval_way                       swap-back invalidate request
//   write_en/way_index_in/tag_in/dirty_in     tag-store install port
//   invalidate_en/invalidate_way              tag-store invalidate port
//   read_en/read_way_index/tag_read/
//   dirty_read/valid_read                     tag-store read port (comb)
//   tag_in_lookup/hit/hit_way_index           tag-store lookup (comb)
//   wb_valid/wb_tag/wb_ready                  dirty-victim writeback
//   busy                                      controller not idle
module vc_insert_ctrl #(
  parameter int unsigned TAG_WIDTH = 20,
  parameter int unsigned NUM_WAYS  = 4,
  localparam int unsigned W        = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evict_valid,
  output logic                 evict_ready,
  input  logic [TAG_WIDTH-1:0] evict_tag,
  input  logic                 evict_dirty,
  input  logic                 inval_req,
  input  logic [W-1:0]         inval_way,
  output logic                 write_en,
  output logic [W-1:0]         way_index_in,
  output logic [TAG_WIDTH-1:0] tag_in,
  output logic                 dirty_in,
  output logic                 invalidate_en,
  output logic [W-1:0]         invalidate_way,
  output logic                 read_en,
  output logic [W-1:0]         read_way_index,
  input  logic [TAG_WIDTH-1:0] tag_read,
  input  logic                 dirty_read,
  input  logic                 valid_read,
  output logic [TAG_WIDTH-1:0] tag_in_lookup,
  input  logic                 hit,
  input  logic [W-1:0]         hit_way_index,
  output logic                 wb_valid,
  output logic [TAG_WIDTH-1:0] wb_tag,
  input  logic                 wb_ready,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, SCAN, VICTIM, WB, INSTALL} state_t;

  localparam logic [W-1:0] LAST_WAY = W'(NUM_WAYS - 1);

  state_t               state, state_d;
  logic [W-1:0]         cnt, cnt_d;
  logic [W-1:0]         rr_ptr, rr_ptr_d;
  logic [W-1:0]         target, target_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0] wb_tag_q, wb_tag_d;
  logic                 victim_q, victim_d;
  // last driven values, so outputs hold while idle
  logic [W-1:0]         rd_idx_q;
  logic [TAG_WIDTH-1:0] tag_in_q;
  logic                 dirty_in_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      target     <= '0;
      tag_q      <= '0;
      dirty_q    <= 1'b0;
      wb_tag_q   <= '0;
      victim_q   <= 1'b0;
      rd_idx_q   <= '0;
      tag_in_q   <= '0;
      dirty_in_q <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rr_ptr   <= rr_ptr_d;
      target   <= target_d;
      tag_q    <= tag_d;
      dirty_q  <= dirty_d;
      wb_tag_q <= wb_tag_d;
      victim_q <= victim_d;
      if (read_en) rd_idx_q <= read_way_index;
      if (write_en) begin
        tag_in_q   <= tag_in;
        dirty_in_q <= dirty_in;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    rr_ptr_d       = rr_ptr;
    target_d       = target;
    tag_d          = tag_q;
    dirty_d        = dirty_q;
    wb_tag_d       = wb_tag_q;
    victim_d       = victim_q;
    evict_ready    = 1'b0;
    read_en        = 1'b0;
    read_way_index = rd_idx_q;
    write_en       = 1'b0;
    way_index_in   = target;
    tag_in         = tag_in_q;
    dirty_in       = dirty_in_q;
    wb_valid       = 1'b0;

    unique case (state)
      IDLE: begin
        evict_ready = 1'b1;
        if (evict_valid) begin
          tag_d    = evict_tag;
          dirty_d  = evict_dirty;
          cnt_d    = '0;
          victim_d = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        read_en = 1'b1;
        if (cnt == '0 && hit) begin
          // duplicate tag: merge dirtiness into the existing way
          read_way_index = hit_way_index;
          target_d       = hit_way_index;
          dirty_d        = dirty_q | dirty_read;
          state_d        = INSTALL;
        end else begin
          read_way_index = cnt;
          if (!valid_read) begin
            target_d = cnt;
            state_d  = INSTALL;
          end else if (cnt == LAST_WAY) begin
            state_d = VICTIM;
          end else begin
            cnt_d = cnt + W'(1);
          end
        end
      end
      VICTIM: begin
        read_en        = 1'b1;
        read_way_index = rr_ptr;
        target_d       = rr_ptr;
        wb_tag_d       = tag_read;
        victim_d       = 1'b1;
        state_d        = dirty_read ? WB : INSTALL;
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = INSTALL;
      end
      INSTALL: begin
        tag_in   = tag_q;
        dirty_in = dirty_q;
        // a pending invalidation holds off the install
        if (!inval_req) begin
          write_en = 1'b1;
          state_d  = IDLE;
          if (victim_q) rr_ptr_d = rr_ptr + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tag_in_lookup  = tag_q;
  assign wb_tag         = wb_tag_q;
  assign invalidate_en  = inval_req;
  assign invalidate_way = inval_way;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_vc_insert_ctrl.sv
// Directed bench for vc_insert_ctrl with a behavioural tag store and a
// scoreboard of expected installs (way, tag, dirty, cycle, writeback tag).
module tb_vc_insert_ctrl;

  localparam int unsigned TW = 20;
  localparam int unsigned NW = 4;
  localparam int unsigned W  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          evict_valid = 1'b0;
  logic          evict_ready;
  logic [TW-1:0] evict_tag = '0;
  logic          evict_dirty = 1'b0;
  logic          inval_req = 1'b0;
  logic [W-1:0]  inval_way = '0;
  logic          write_en;
  logic [W-1:0]  way_index_in;
  logic [TW-1:0] tag_in;
  logic          dirty_in;
  logic          invalidate_en;
  logic [W-1:0]  invalidate_way;
  logic          read_en;
  logic [W-1:0]  read_way_index;
  logic [TW-1:0] tag_read;
  logic          dirty_read;
  logic          valid_read;
  logic [TW-1:0] tag_in_lookup;
  logic          hit;
  logic [W-1:0]  hit_way_index;
  logic          wb_valid;
  logic [TW-1:0] wb_tag;
  logic          wb_ready;
  logic          busy;

  vc_insert_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_tag(evict_tag), .evict_dirty(evict_dirty),
    .inval_req(inval_req), .inval_way(inval_way),
    .write_en(write_en), .way_index_in(way_index_in),
    .tag_in(tag_in), .dirty_in(dirty_in),
    .invalidate_en(invalidate_en), .invalidate_way(invalidate_way),
    .read_en(read_en), .read_way_index(read_way_index),
    .tag_read(tag_read), .dirty_read(dirty_read), .valid_read(valid_read),
    .tag_in_lookup(tag_in_lookup), .hit(hit), .hit_way_index(hit_way_index),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_ready(wb_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // ---------------- behavioural tag store ----------------
  logic [TW-1:0] mtag   [NW];
  logic          mvalid [NW];
  logic          mdirty [NW];
  logic          pl_en = 1'b0;
  logic [W-1:0]  pl_way = '0;
  logic [TW-1:0] pl_tag = '0;
  logic          pl_dirty = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        mtag[i] <= '0; mvalid[i] <= 1'b0; mdirty[i] <= 1'b0;
      end
    end else begin
      if (pl_en) begin
        mtag[pl_way] <= pl_tag; mvalid[pl_way] <= 1'b1; mdirty[pl_way] <= pl_dirty;
      end
      if (write_en) begin
        mtag[way_index_in] <= tag_in; mvalid[way_index_in] <= 1'b1; mdirty[way_index_in] <= dirty_in;
      end
      if (invalidate_en) mvalid[invalidate_way] <= 1'b0;
    end
  end

  assign tag_read   = mtag[read_way_index];
  assign dirty_read = mdirty[read_way_index];
  assign valid_read = mvalid[read_way_index];

  always_comb begin
    hit = 1'b0;
    hit_way_index = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (mvalid[i] && mtag[i] == tag_in_lookup) begin
        hit = 1'b1;
        hit_way_index = W'(i);
      end
    end
  end

  // ---------------- writeback responder ----------------
  int wb_stall = 0;
  int wb_hi = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) wb_hi <= 0;
    else     wb_hi <= (wb_valid && !wb_ready) ? wb_hi + 1 : 0;
  end
  assign wb_ready = wb_valid && (wb_hi >= wb_stall);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0]  way;
    logic [TW-1:0] tag;
    logic          dirty;
    int            cyc;
    logic          has_wb;
    logic [TW-1:0] wb_tag;
  } sb_t;

  sb_t sb[$];
  int  wb_seen = 0;
  int  last_wb_cnt = 0;
  logic [W-1:0] exp_rr = '0;

  // Install/writeback monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      wb_seen = 0;
    end else begin
      if (wb_valid) begin
        wb_seen++;
        if (sb.size() == 0) check("wb_unexpected", 32'(sb.size()), 32'd1);
        else begin
          check("wb_expected", 32'(sb[0].has_wb), 32'd1);
          check("wb_tag", 32'(wb_tag), 32'(sb[0].wb_tag));
        end
      end
      if (write_en) begin
        if (sb.size() == 0) check("write_unexpected", 32'(sb.size()), 32'd1);
        else begin
          sb_t e;
          e = sb.pop_front();
          check("install_way",   32'(way_index_in), 32'(e.way));
          check("install_tag",   32'(tag_in),       32'(e.tag));
          check("install_dirty", 32'(dirty_in),     32'(e.dirty));
          check("install_cycle", 32'(cyc),          32'(e.cyc));
          last_wb_cnt = wb_seen;
          wb_seen = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    exp_rr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input logic [W-1:0] way, input logic [TW-1:0] tag, input logic d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_way = way; pl_tag = tag; pl_dirty = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Offer one eviction and push its predicted install; optional invalidate
  // held for inval_cycles at the start of the expected INSTALL.
  task automatic do_evict(input logic [TW-1:0] tag, input logic d,
                          input int inval_cycles, input logic [W-1:0] iway);
    sb_t e;
    int  lat;
    bool_found: begin end
    @(posedge clk); #1;
    evict_tag = tag; evict_dirty = d; evict_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (evict_ready) break;
    end
    check("accept_ready", 32'(evict_ready), 32'd1);
    e.tag = tag; e.dirty = d; e.has_wb = 1'b0; e.wb_tag = '0; e.way = '0;
    lat = -1;
    for (int i = 0; i < NW; i++)
      if (lat < 0 && mvalid[i] && mtag[i] == tag) begin
        e.way = W'(i); e.dirty = d | mdirty[i]; lat = 2;
      end
    for (int i = 0; i < NW; i++)
      if (lat < 0 && !mvalid[i]) begin
        e.way = W'(i); lat = i + 2;
      end
    if (lat < 0) begin
      e.way = exp_rr;
      lat = NW + 2;
      if (mdirty[exp_rr]) begin
        e.has_wb = 1'b1; e.wb_tag = mtag[exp_rr]; lat += 1 + wb_stall;
      end
      exp_rr = exp_rr + W'(1);
    end
    e.cyc = cyc + lat + inval_cycles;
    sb.push_back(e);
    @(posedge clk); #1;
    evict_valid = 1'b0;
    if (inval_cycles > 0) begin
      repeat (lat - 1) @(posedge clk);
      #1;
      inval_req = 1'b1; inval_way = iway;
      for (int c = 0; c < inval_cycles; c++) begin
        @(negedge clk);
        check("inval_en",     32'(invalidate_en),  32'd1);
        check("inval_way",    32'(invalidate_way), 32'(iway));
        check("inval_no_wr",  32'(write_en),       32'd0);
        @(posedge clk); #1;
      end
      inval_req = 1'b0;
    end
  endtask

  task automatic drain(input logic [W-1:0] way, input logic [TW-1:0] tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("idle_busy",    32'(busy),         32'd0);
    check("idle_ready",   32'(evict_ready),  32'd1);
    check("idle_read_en", 32'(read_en),      32'd0);
    check("idle_wb",      32'(wb_valid),     32'd0);
    check("hold_way",     32'(way_index_in), 32'(way));
    check("hold_tag",     32'(tag_in),       32'(tag));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    check("rst_ready",  32'(evict_ready),    32'd1);
    check("rst_busy",   32'(busy),           32'd0);
    check("rst_wr",     32'(write_en),       32'd0);
    check("rst_rd",     32'(read_en),        32'd0);
    check("rst_wb",     32'(wb_valid),       32'd0);
    check("rst_way",    32'(way_index_in),   32'd0);
    check("rst_tag",    32'(tag_in),         32'd0);
    check("rst_rdidx",  32'(read_way_index), 32'd0);
    check("rst_wbtag",  32'(wb_tag),         32'd0);
    check("rst_lookup", 32'(tag_in_lookup),  32'd0);
    do_reset();

    // empty store fills from way 0, then duplicate tag merges dirtiness
    do_evict(20'h00ABC, 1'b0, 0, '0); drain(2'd0, 20'h00ABC);
    do_evict(20'h00BBB, 1'b0, 0, '0); drain(2'd1, 20'h00BBB);
    do_evict(20'h00123, 1'b1, 0, '0); drain(2'd2, 20'h00123);
    do_evict(20'h00123, 1'b0, 0, '0); drain(2'd2, 20'h00123);

    // full clean store: round-robin 0,1,2,3,0 with no writeback
    do_reset();
    for (int i = 0; i < NW; i++) preload(W'(i), 20'hA0000 + TW'(i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      do_evict(20'hB0000 + TW'(k), 1'b0, 0, '0);
      drain(W'(k % NW), 20'hB0000 + TW'(k));
      check("clean_no_wb", 32'(last_wb_cnt), 32'd0);
    end

    // full store, dirty victim in way 0, memory stalls 3 cycles
    do_reset();
    preload(2'd0, 20'h0F00F, 1'b1);
    for (int i = 1; i < NW; i++) preload(W'(i), 20'h10000 + TW'(i), 1'b0);
    wb_stall = 3;
    do_evict(20'h55555, 1'b0, 0, '0); drain(2'd0, 20'h55555);
    check("wb_len", 32'(last_wb_cnt), 32'd4);
    wb_stall = 0;

    // invalidation held two cycles blocks the install
    do_reset();
    preload(2'd3, 20'h77777, 1'b0);
    do_evict(20'h00D00, 1'b0, 2, 2'd3); drain(2'd0, 20'h00D00);
    check("inval_applied", 32'(mvalid[3]), 32'd0);
    do_evict(20'h00E00, 1'b1, 0, '0); drain(2'd1, 20'h00E00);

    // reset during writeback drops the handshake at once
    do_reset();
    preload(2'd0, 20'h0F00F, 1'b1);
    for (int i = 1; i < NW; i++) preload(W'(i), 20'h20000 + TW'(i), 1'b0);
    wb_stall = 1000;
    do_evict(20'h66666, 1'b0, 0, '0);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (wb_valid) break;
    end
    check("wb_reached", 32'(wb_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    exp_rr = '0;
    #1;
    check("rstwb_wb",    32'(wb_valid),    32'd0);
    check("rstwb_ready", 32'(evict_ready), 32'd1);
    check("rstwb_busy",  32'(busy),        32'd0);
    check("rstwb_wr",    32'(write_en),    32'd0);
    inval_req = 1'b1; inval_way = 2'd2;
    #1;
    check("rst_inval_en",  32'(invalidate_en),  32'd1);
    check("rst_inval_way", 32'(invalidate_way), 32'd2);
    inval_req = 1'b0;
    wb_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_evict(20'h0EEEE, 1'b0, 0, '0); drain(2'd0, 20'h0EEEE);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_insert_ctrl.md
VC_INSERT_CTRL -- requirements
Module: vc_insert_ctrl

Interface
REQ-001 Parameters SHALL be: TAG_WIDTH, default 20, tag width; NUM_WAYS, default 4, victim-cache ways (power of 2, >=2); W = $clog2(NUM_WAYS).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 evict_valid  in  1  L1 eviction offered; evict_ready  out  1  controller accepts eviction.
REQ-005 evict_tag  in  TAG_WIDTH  evicted line tag; evict_dirty  in  1  evicted line dirty.
REQ-006 inval_req  in  1  swap-back invalidate request; inval_way  in  W  way to invalidate.
REQ-007 write_en  out  1; way_index_in  out  W; tag_in  out  TAG_WIDTH; dirty_in  out  1: install port to the tag store.
REQ-008 invalidate_en  out  1; invalidate_way  out  W: invalidate port to the tag store.
REQ-009 read_en  out  1; read_way_index  out  W; tag_read  in  TAG_WIDTH; dirty_read  in  1; valid_read  in  1: combinational tag-store read port.
REQ-010 tag_in_lookup  out  TAG_WIDTH; hit  in  1; hit_way_index  in  W: combinational tag-store lookup.
REQ-011 wb_valid  out  1; wb_tag  out  TAG_WIDTH; wb_ready  in  1: dirty-victim writeback handshake to memory.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, VICTIM, WB, INSTALL.
REQ-014 IDLE: evict_ready=1; on evict_valid&&evict_ready, capture evict_tag/evict_dirty into tag_q/dirty_q, clear scan counter cnt, go SCAN.
REQ-015 tag_in_lookup SHALL equal tag_q at all times.
REQ-016 SCAN first cycle (cnt==0) with hit=1: target=hit_way_index, read_way_index=hit_way_index, dirty_q <= dirty_q|dirty_read, go INSTALL (duplicate-tag merge; no second copy ever installed).
REQ-017 SCAN otherwise: read_en=1, read_way_index=cnt; valid_read=0 -> target=cnt, go INSTALL; valid_read=1 and cnt<NUM_WAYS-1 -> cnt+1; valid_read=1 and cnt==NUM_WAYS-1 -> go VICTIM.
REQ-018 Lowest-numbered invalid way SHALL always be chosen.
REQ-019 VICTIM (one cycle): read way rr_ptr, target=rr_ptr, capture tag_read into wb_tag_q; dirty_read=1 -> WB, else INSTALL.
REQ-020 WB: wb_valid=1, wb_tag=wb_tag_q, both stable until wb_ready; wb_valid&&wb_ready -> INSTALL.
REQ-021 INSTALL: if inval_req=0, write_en=1 for exactly one cycle with way_index_in=target, tag_in=tag_q, dirty_in=dirty_q, then IDLE; if inval_req=1, write_en=0 and stay in INSTALL.
REQ-022 rr_ptr SHALL advance (mod NUM_WAYS, wrap NUM_WAYS-1 -> 0) only on the INSTALL write following a VICTIM replacement.
REQ-023 invalidate_en=inval_req and invalidate_way=inval_way combinationally in every state; invalidation always wins over install.
REQ-024 Latency from acceptance cycle T: empty cache -> write_en at T+2; duplicate hit -> T+2; full clean -> T+NUM_WAYS+2; full dirty -> T+NUM_WAYS+3+wb stall cycles.
REQ-025 evict_ready=0 in every non-IDLE state; no eviction is lost or accepted twice.
REQ-026 Outside active states read_en=0, write_en=0, wb_valid=0; read_way_index/way_index_in/tag_in/dirty_in/wb_tag hold last value.

Reset
REQ-027 rst SHALL immediately force state=IDLE, cnt=0, rr_ptr=0, tag_q/dirty_q/wb_tag_q/target=0.
REQ-028 Reset values: evict_ready=1, busy=0, write_en=0, wb_valid=0, read_en=0, all index/data outputs 0; invalidate_en follows inval_req.
REQ-029 Reset mid-WB or mid-INSTALL SHALL drop wb_valid/write_en at once; in-flight eviction discarded.

Verification
REQ-030 Empty store, evict tag 0x00ABC dirty=0 -> write_en at T+2, way 0, tag 0x00ABC, dirty 0; second eviction -> way 1.
REQ-031 Way 2 holds 0x00123 dirty=1; evict 0x00123 dirty=0 -> write_en T+2, way 2, dirty_in=1; no other way written.
REQ-032 All 4 ways valid clean, rr_ptr=0 -> SCAN 4 cycles, write_en T+6 to way 0, wb_valid never high, rr_ptr=1; repeat x4 -> ways 1,2,3,0 (wrap).
REQ-033 All ways valid, way 0 dirty tag 0x0F00F, wb_ready low 3 cycles -> wb_valid high 4 cycles, wb_tag=0x0F00F stable, write_en one cycle after handshake.
REQ-034 inval_req=1 held 2 cycles during INSTALL -> invalidate_en=1, write_en=0 for 2 cycles, install occurs on third cycle.
REQ-035 Assert rst during WB -> wb_valid=0, evict_ready=1, busy=0 same cycle; next eviction installs to way 0 in an empty store.
